wr_ctrl_wb: RTL and testbench

- Next-generation cache write controller: a parametrised posted-write buffer (WB_DEPTH entries) in front of a line-allocate / fetch / commit engine.
- Adds byte enables, FIFO-ordered retirement and same-line back-to-back commits that skip the lookup.
- Sits between the accelerator write port and the line-status table, fetch engine and data SRAM.
- Coordinates with the read controller through busy/address conflict signals.

---
 rtl/wr_ctrl_wb.sv | 210 +++++++++++++++++++++
 tb/tb_wr_ctrl_wb.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wr_ctrl_wb.sv
// Cache write controller: posted-write FIFO with byte enables feeding a
// lookup / allocate / fetch / commit engine, retiring strictly in FIFO order.
module wr_ctrl_wb #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LIST_DEPTH = 4,
  parameter int LINE_WORDS = 32,
  parameter int WB_DEPTH   = 4,
  localparam int TAG_W = $clog2(LIST_DEPTH),
  localparam int OFS_W = $clog2(LINE_WORDS),
  localparam int BE_W  = DATA_W / 8,
  localparam int PTR_W = $clog2(WB_DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   acc_wr_valid,
  output logic                   acc_wr_ready,
  input  logic [ADDR_W-1:0]      acc_wr_addr,
  input  logic [DATA_W-1:0]      acc_wr_data,
  input  logic [BE_W-1:0]        acc_wr_be,
  output logic                   lkp_req,
  output logic [ADDR_W-1:0]      lkp_index,
  input  logic                   lkp_hit,
  input  logic [TAG_W-1:0]       lkp_tag,
  output logic                   alloc_req,
  input  logic                   alloc_gnt,
  input  logic [TAG_W-1:0]       alloc_tag,
  input  logic                   alloc_dirty,
  input  logic [ADDR_W-1:0]      alloc_victim,
  output logic                   fetch_req,
  input  logic                   fetch_gnt,
  output logic [ADDR_W-1:0]      fetch_addr,
  output logic [TAG_W-1:0]       fetch_tag,
  output logic                   fetch_wb,
  output logic [ADDR_W-1:0]      fetch_wb_addr,
  input  logic                   fetch_done,
  input  logic                   rd_busy,
  input  logic [ADDR_W-1:0]      rd_busy_addr,
  output logic                   wr_busy,
  output logic [ADDR_W-1:0]      wr_busy_addr,
  output logic                   mem_wen,
  input  logic                   mem_wready,
  output logic [TAG_W+OFS_W-1:0] mem_waddr,
  output logic [DATA_W-1:0]      mem_wdata,
  output logic [BE_W-1:0]        mem_wbe,
  output logic [CNT_W-1:0]       wb_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_CONFLICT, S_ALLOC, S_FETCH, S_WAIT_FETCH, S_WRITE
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_mem_q [WB_DEPTH];
  logic [DATA_W-1:0] data_mem_q [WB_DEPTH];
  logic [BE_W-1:0]   be_mem_q   [WB_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q, nx_ptr_s;
  logic [CNT_W-1:0]  count_q;

  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              dirty_q, dirty_d;
  logic [ADDR_W-1:0] victim_q, victim_d;

  logic              push_s, pop_s, conflict_s, same_next_s;
  logic [ADDR_W-1:0] head_addr_s, head_line_s, next_line_s;
  logic [BE_W-1:0]   head_be_s;

  assign acc_wr_ready = !rst && (count_q < CNT_W'(WB_DEPTH));
  assign push_s       = acc_wr_valid && acc_wr_ready;
  assign wb_count     = count_q;

  assign nx_ptr_s    = rd_ptr_q + PTR_W'(1);
  assign head_addr_s = addr_mem_q[rd_ptr_q];
  assign head_be_s   = be_mem_q[rd_ptr_q];
  assign head_line_s = {head_addr_s[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
  assign next_line_s = {addr_mem_q[nx_ptr_s][ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
  assign conflict_s  = rd_busy && (rd_busy_addr == head_line_s);
  // Next entry may reuse the tag only if it is really there, same line, and not a drop.
  assign same_next_s = (count_q >= CNT_W'(2)) && (next_line_s == head_line_s)
                       && (be_mem_q[nx_ptr_s] != '0);

  // Buffer storage; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      addr_mem_q[wr_ptr_q] <= acc_wr_addr;
      data_mem_q[wr_ptr_q] <= acc_wr_data;
      be_mem_q[wr_ptr_q]   <= acc_wr_be;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tag_q    <= '0;
      dirty_q  <= 1'b0;
      victim_q <= '0;
      state_q  <= S_IDLE;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_s)  rd_ptr_q <= nx_ptr_s;
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      tag_q    <= tag_d;
      dirty_q  <= dirty_d;
      victim_q <= victim_d;
      state_q  <= state_d;
    end
  end

  always_comb begin
    tag_d    = tag_q;
    dirty_d  = dirty_q;
    victim_d = victim_q;
    if (state_q == S_LOOKUP && head_be_s != '0 && !conflict_s && lkp_hit) begin
      tag_d = lkp_tag;
    end else if (state_q == S_ALLOC && alloc_gnt) begin
      tag_d    = alloc_tag;
      dirty_d  = alloc_dirty;
      victim_d = alloc_victim;
    end else begin
      tag_d = tag_q;
    end
  end

  // IDLE also looks at the push so an isolated write reaches LOOKUP one cycle later.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       state_d = (count_q != '0 || push_s) ? S_LOOKUP : S_IDLE;
      S_LOOKUP: begin
        if (head_be_s == '0)      state_d = (count_q >= CNT_W'(2)) ? S_LOOKUP : S_IDLE;
        else if (conflict_s)      state_d = S_CONFLICT;
        else if (lkp_hit)         state_d = S_WRITE;
        else                      state_d = S_ALLOC;
      end
      S_CONFLICT:   state_d = conflict_s ? S_CONFLICT : S_LOOKUP;
      S_ALLOC:      state_d = alloc_gnt ? S_FETCH : S_ALLOC;
      S_FETCH:      state_d = fetch_gnt ? S_WAIT_FETCH : S_FETCH;
      S_WAIT_FETCH: state_d = fetch_done ? S_WRITE : S_WAIT_FETCH;
      S_WRITE: begin
        if (!mem_wready)                 state_d = S_WRITE;
        else if (same_next_s)            state_d = S_WRITE;
        else if (count_q >= CNT_W'(2))   state_d = S_LOOKUP;
        else                             state_d = S_IDLE;
      end
      default:      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    lkp_req       = 1'b0;
    lkp_index     = '0;
    alloc_req     = 1'b0;
    fetch_req     = 1'b0;
    fetch_addr    = '0;
    fetch_tag     = '0;
    fetch_wb      = 1'b0;
    fetch_wb_addr = '0;
    wr_busy       = 1'b0;
    wr_busy_addr  = '0;
    mem_wen       = 1'b0;
    mem_waddr     = '0;
    mem_wdata     = '0;
    mem_wbe       = '0;
    pop_s         = 1'b0;
    case (state_q)
      S_LOOKUP: begin
        lkp_req   = 1'b1;
        lkp_index = head_line_s;
        pop_s     = (head_be_s == '0);
      end
      S_ALLOC: begin
        alloc_req    = 1'b1;
        wr_busy      = 1'b1;
        wr_busy_addr = head_line_s;
      end
      S_FETCH: begin
        fetch_req     = 1'b1;
        fetch_addr    = head_line_s;
        fetch_tag     = tag_q;
        fetch_wb      = dirty_q;
        fetch_wb_addr = victim_q;
        wr_busy       = 1'b1;
        wr_busy_addr  = head_line_s;
      end
      S_WAIT_FETCH: begin
        wr_busy      = 1'b1;
        wr_busy_addr = head_line_s;
      end
      S_WRITE: begin
        mem_wen      = 1'b1;
        mem_waddr    = {tag_q, head_addr_s[OFS_W-1:0]};
        mem_wdata    = data_mem_q[rd_ptr_q];
        mem_wbe      = head_be_s;
        pop_s        = mem_wready;
        wr_busy      = 1'b1;
        wr_busy_addr = head_line_s;
      end
      default: pop_s = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_wr_ctrl_wb.sv
// Directed bench for wr_ctrl_wb: hand-computed vectors applied cycle by cycle,
// inputs driven 1ns after the rising edge and outputs checked 1ns later.
module tb_wr_ctrl_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        acc_wr_valid;
  logic        acc_wr_ready;
  logic [31:0] acc_wr_addr;
  logic [31:0] acc_wr_data;
  logic [3:0]  acc_wr_be;
  logic        lkp_req;
  logic [31:0] lkp_index;
  logic        lkp_hit;
  logic [1:0]  lkp_tag;
  logic        alloc_req;
  logic        alloc_gnt;
  logic [1:0]  alloc_tag;
  logic        alloc_dirty;
  logic [31:0] alloc_victim;
  logic        fetch_req;
  logic        fetch_gnt;
  logic [31:0] fetch_addr;
  logic [1:0]  fetch_tag;
  logic        fetch_wb;
  logic [31:0] fetch_wb_addr;
  logic        fetch_done;
  logic        rd_busy;
  logic [31:0] rd_busy_addr;
  logic        wr_busy;
  logic [31:0] wr_busy_addr;
  logic        mem_wen;
  logic        mem_wready;
  logic [6:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wbe;
  logic [2:0]  wb_count;

  int n_vec = 0;
  int n_err = 0;

  wr_ctrl_wb dut (
    .clk(clk), .rst(rst),
    .acc_wr_valid(acc_wr_valid), .acc_wr_ready(acc_wr_ready),
    .acc_wr_addr(acc_wr_addr), .acc_wr_data(acc_wr_data), .acc_wr_be(acc_wr_be),
    .lkp_req(lkp_req), .lkp_index(lkp_index), .lkp_hit(lkp_hit), .lkp_tag(lkp_tag),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
    .alloc_dirty(alloc_dirty), .alloc_victim(alloc_victim),
    .fetch_req(fetch_req), .fetch_gnt(fetch_gnt), .fetch_addr(fetch_addr),
    .fetch_tag(fetch_tag), .fetch_wb(fetch_wb), .fetch_wb_addr(fetch_wb_addr),
    .fetch_done(fetch_done), .rd_busy(rd_busy), .rd_busy_addr(rd_busy_addr),
    .wr_busy(wr_busy), .wr_busy_addr(wr_busy_addr),
    .mem_wen(mem_wen), .mem_wready(mem_wready), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_wbe(mem_wbe), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    acc_wr_valid = 1'b0; acc_wr_addr = 32'h0; acc_wr_data = 32'h0; acc_wr_be = 4'h0;
    lkp_hit = 1'b0; lkp_tag = 2'd0;
    alloc_gnt = 1'b0; alloc_tag = 2'd0; alloc_dirty = 1'b0; alloc_victim = 32'h0;
    fetch_gnt = 1'b0; fetch_done = 1'b0;
    rd_busy = 1'b0; rd_busy_addr = 32'h0; mem_wready = 1'b0;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    acc_wr_valid = 1'b1; acc_wr_addr = a; acc_wr_data = d; acc_wr_be = be;
  endtask

  int          n_lkp;
  int          n_cm;
  logic [6:0]  cm_addr [4];
  logic [31:0] cm_data [4];

  initial begin
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    #1;
    chk("rst_ready", acc_wr_ready, 1'b0);
    chk("rst_count", wb_count, 3'd0);
    chk("rst_reqs", {lkp_req, alloc_req, fetch_req, mem_wen, wr_busy}, 5'b0);

    // 1: isolated hit, addr 0x44 -> line 0x40, offset 4, tag 2
    rst = 1'b0;
    push(32'h44, 32'hDEADBEEF, 4'hF);
    lkp_hit = 1'b1; lkp_tag = 2'd2; mem_wready = 1'b1;
    #1;
    chk("t1_ready_c0", acc_wr_ready, 1'b1);
    chk("t1_lkp_c0", lkp_req, 1'b0);
    step();
    acc_wr_valid = 1'b0;
    #1;
    chk("t1_lkp_c1", lkp_req, 1'b1);
    chk("t1_index_c1", lkp_index, 32'h40);
    chk("t1_count_c1", wb_count, 3'd1);
    chk("t1_ready_c1", acc_wr_ready, 1'b1);
    chk("t1_wen_c1", mem_wen, 1'b0);
    step();
    #1;
    chk("t1_wen_c2", mem_wen, 1'b1);
    chk("t1_waddr_c2", mem_waddr, 7'h44);
    chk("t1_wdata_c2", mem_wdata, 32'hDEADBEEF);
    chk("t1_wbe_c2", mem_wbe, 4'hF);
    chk("t1_busy_c2", {wr_busy, wr_busy_addr}, {1'b1, 32'h40});
    step();
    #1;
    chk("t1_count_c3", wb_count, 3'd0);
    chk("t1_wen_c3", mem_wen, 1'b0);

    // 2: four pushes to line 0x80, SRAM stalled for 5 cycles, then same-line bypass
    idle_inputs();
    lkp_hit = 1'b1; lkp_tag = 2'd1;
    n_lkp = 0;
    for (int c = 0; c < 10; c++) begin
      acc_wr_valid = (c < 4);
      acc_wr_addr  = 32'h80 + 32'(c);
      acc_wr_data  = 32'h100 + 32'(c);
      acc_wr_be    = 4'hF;
      mem_wready   = (c >= 5);
      #1;
      if (lkp_req) n_lkp++;
      if (c == 4) begin
        chk("t2_full_ready", acc_wr_ready, 1'b0);
        chk("t2_full_count", wb_count, 3'd4);
      end
      if (c >= 5 && c <= 8) begin
        chk("t2_wen", mem_wen, 1'b1);
        chk("t2_waddr", mem_waddr, 7'(32 + c - 5));
        chk("t2_wdata", mem_wdata, 32'h100 + 32'(c - 5));
      end
      if (c == 9) chk("t2_count_end", wb_count, 3'd0);
      step();
    end
    chk("t2_lkp_once", n_lkp, 1);

    // 3: miss, dirty victim 0x200, alloc tag 1; addr 0x123 -> line 0x120 offset 3
    idle_inputs();
    mem_wready = 1'b1;
    push(32'h123, 32'h0000A5A5, 4'h3);
    step();
    acc_wr_valid = 1'b0;
    #1;
    chk("t3_lkp", {lkp_req, lkp_index}, {1'b1, 32'h120});
    step();
    #1;
    chk("t3_alloc_c2", {alloc_req, wr_busy, wr_busy_addr}, {2'b11, 32'h120});
    step();
    alloc_gnt = 1'b1; alloc_tag = 2'd1; alloc_dirty = 1'b1; alloc_victim = 32'h200;
    #1;
    chk("t3_alloc_c3", alloc_req, 1'b1);
    step();
    alloc_gnt = 1'b0; alloc_tag = 2'd0; alloc_dirty = 1'b0; alloc_victim = 32'h0;
    #1;
    chk("t3_fetch_c4", {fetch_req, fetch_addr, fetch_tag, fetch_wb, fetch_wb_addr},
        {1'b1, 32'h120, 2'd1, 1'b1, 32'h200});
    chk("t3_noalloc_c4", alloc_req, 1'b0);
    step();
    fetch_gnt = 1'b1;
    #1;
    chk("t3_fetch_c5", {fetch_req, fetch_addr, fetch_tag, fetch_wb, fetch_wb_addr},
        {1'b1, 32'h120, 2'd1, 1'b1, 32'h200});
    step();
    fetch_gnt = 1'b0;
    #1;
    chk("t3_wait_c6", {fetch_req, mem_wen, wr_busy}, 3'b001);
    step();
    #1;
    chk("t3_wait_c7", {mem_wen, wr_busy}, 2'b01);
    step();
    fetch_done = 1'b1;
    #1;
    chk("t3_wait_c8", mem_wen, 1'b0);
    step();
    fetch_done = 1'b0;
    #1;
    chk("t3_write_c9", {mem_wen, mem_waddr, mem_wdata, mem_wbe, wr_busy},
        {1'b1, 7'h23, 32'h0000A5A5, 4'h3, 1'b1});
    step();
    #1;
    chk("t3_end_c10", {wb_count, wr_busy}, {3'd0, 1'b0});

    // 4: reader owns line 0x40 for 6 cycles; addr 0x45 must wait then re-look-up
    idle_inputs();
    lkp_hit = 1'b1; lkp_tag = 2'd3; mem_wready = 1'b1;
    rd_busy_addr = 32'h40;
    for (int c = 0; c < 10; c++) begin
      acc_wr_valid = (c == 0);
      acc_wr_addr  = 32'h45;
      acc_wr_data  = 32'h55;
      acc_wr_be    = 4'hF;
      rd_busy      = (c < 6);
      #1;
      if (c == 1) chk("t4_lkp_first", lkp_req, 1'b1);
      if (c >= 2 && c <= 6) chk("t4_held", {lkp_req, alloc_req, mem_wen, wr_busy}, 4'b0);
      if (c == 7) chk("t4_relookup", {lkp_req, lkp_index}, {1'b1, 32'h40});
      if (c == 8) chk("t4_write", {mem_wen, mem_waddr, mem_wdata}, {1'b1, 7'h65, 32'h55});
      if (c == 9) chk("t4_count_end", wb_count, 3'd0);
      step();
    end

    // 5: zero-byte-enable entry between two real writes is dropped
    idle_inputs();
    lkp_hit = 1'b1; lkp_tag = 2'd0; mem_wready = 1'b1;
    n_cm = 0;
    for (int c = 0; c < 8; c++) begin
      acc_wr_valid = (c < 3);
      acc_wr_addr  = 32'h10 + 32'(c);
      acc_wr_data  = (c == 0) ? 32'h11 : (c == 1) ? 32'h22 : 32'h33;
      acc_wr_be    = (c == 1) ? 4'h0 : 4'hF;
      #1;
      if (mem_wen && mem_wready && n_cm < 4) begin
        cm_addr[n_cm] = mem_waddr;
        cm_data[n_cm] = mem_wdata;
        n_cm++;
      end
      step();
    end
    chk("t5_ncommit", n_cm, 2);
    chk("t5_c0", {cm_addr[0], cm_data[0]}, {7'h10, 32'h11});
    chk("t5_c1", {cm_addr[1], cm_data[1]}, {7'h12, 32'h33});
    chk("t5_count_end", wb_count, 3'd0);

    // 6: reset while waiting for a fetch with three entries buffered
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      acc_wr_valid = (c < 3);
      acc_wr_addr  = 32'h300 + 32'(c);
      acc_wr_data  = 32'h9;
      acc_wr_be    = 4'hF;
      alloc_gnt    = (c == 2);
      alloc_tag    = 2'd2;
      fetch_gnt    = (c == 3);
      step();
    end
    idle_inputs();
    #1;
    chk("t6_waiting", {wr_busy, fetch_req, wb_count}, {1'b1, 1'b0, 3'd3});
    rst = 1'b1;
    step();
    #1;
    chk("t6_rst_outs", {acc_wr_ready, lkp_req, alloc_req, fetch_req, fetch_wb,
                        mem_wen, wr_busy, wb_count}, 10'b0);
    chk("t6_rst_addrs", {fetch_addr, wr_busy_addr, mem_waddr}, 71'b0);
    step();
    rst = 1'b0; fetch_done = 1'b1; mem_wready = 1'b1;
    #1;
    chk("t6_ready_back", acc_wr_ready, 1'b1);
    chk("t6_nowen_c6", mem_wen, 1'b0);
    step();
    fetch_done = 1'b0;
    #1;
    chk("t6_after", {mem_wen, fetch_req, lkp_req, alloc_req, wb_count}, 7'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
